fft_frame_sequencer: RTL and testbench
======================================

// Module: fft_frame_sequencer
// PURPOSE
// - Top-level frame scheduler for the FFT accelerator: RX (AXIS slave IF fills FFT mem) -> COMPUTE (core) -> TX (AXIS master IF drains mem).
// - Grants exclusive FFT memory ownership to one agent per phase and generates start pulses and frame-latched config.
// - Watchdog on every phase; status and frame count go to the AXI-Lite register block.
// PARAMETERS
// - TIMEOUT_CYCLES  default 2**20  max cycles per phase before ERROR; 0 = watchdog disabled
// - FRAME_CNT_WDT   default 16     width of completed-frame counter
// PORTS
// - clk          in   1   system clock
// - rst          in   1   synchronous reset, active-high
// - cfg_en       in   1   level; sequencer may start new frames while high
// - cfg_inverse  in   1   IFFT select, sampled on IDLE->RX
// - err_clr      in   1   pulse; leaves ERROR state
// - rx_ready     out  1   level; slave IF may accept a frame
// - rx_done      in   1   pulse; slave IF wrote the last sample
// - fft_start    out  1   1-cycle pulse; start core
// - fft_inverse  out  1   frame-latched copy of cfg_inverse
// - fft_done     in   1   pulse; core finished all stages
// - tx_ready     out  1   1-cycle pulse; start master IF
// - tx_busy      in   1   master IF busy (m_axis_if_busy)
// - mem_owner    out  2   0 NONE, 1 RX, 2 CORE, 3 TX: FFT memory port mux select
// - seq_busy     out  1   state != IDLE
// - seq_err      out  1   high in ERROR
// - err_phase    out  2   mem_owner value at timeout, held until err_clr
// - frame_cnt    out  FRAME_CNT_WDT  completed frames, wraps
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; fft_inverse 0; frame_cnt 0; watchdog 0.
// - States: IDLE, RX, CORE_START, CORE, TX_START, TX_WAIT, TX, ERROR.
// - IDLE: cfg_en=1 -> RX next cycle; latch fft_inverse<=cfg_inverse.
// - RX: rx_ready=1, mem_owner=RX; rx_done -> CORE_START.
// - CORE_START: fft_start=1 (exactly 1 cycle), mem_owner=CORE -> CORE.
// - CORE: mem_owner=CORE; fft_done -> TX_START.
// - TX_START: tx_ready=1 (exactly 1 cycle), mem_owner=TX -> TX_WAIT.
// - TX_WAIT: waits for tx_busy=1 -> TX.
// - TX: tx_busy=0 -> frame_cnt+1; -> RX if cfg_en else IDLE (re-latch fft_inverse on -> RX).
// - Done/start pulses ignored in states that do not expect them; a stray pulse never advances the FSM.
// - rx_done and fft_done in their phase's first cycle are accepted.
// - mem_owner is registered and changes in the same cycle as the state register; never two owners.
// - Watchdog: counter clears on each state change; increments in RX, CORE, TX_WAIT, TX.
//   - Count == TIMEOUT_CYCLES-1 and no completion that cycle -> ERROR.
//   - Completion in the same cycle as timeout wins (no error).
//   - RX is exempt while cfg_en=0: waiting for input is not a fault.
// - ERROR: seq_err=1, mem_owner=NONE, err_phase held; err_clr -> IDLE (frame_cnt kept).
// - cfg_en dropping mid-frame: current frame completes, then IDLE. No abort.
// - frame_cnt wraps 2**FRAME_CNT_WDT-1 -> 0 silently.
// STRUCTURE
// - fft_ctrl_pckg:
//   - typedef enum seq_state_t (states above)
//   - typedef enum logic [1:0] mem_owner_t {OWN_NONE, OWN_RX, OWN_CORE, OWN_TX}
//   - localparam SEQ_TIMEOUT_DFLT
// - One sub-module fft_seq_watchdog: clear, enable, TIMEOUT_CYCLES param, expired flag; bypassed when TIMEOUT_CYCLES = 0.
// - FSM, pulse generation and frame counter stay in the top.
// TESTING
// - Nominal frame: cfg_en=1, cfg_inverse=1.
//   - rx_done @10 -> fft_start @11, mem_owner 2 @11.
//   - fft_done @30 -> tx_ready @31.
//   - tx_busy 32..60 -> frame_cnt=1 @61, rx_ready=1 @61, fft_inverse=1.
// - Back-to-back: 3 frames with cfg_inverse toggled 1->0 before frame 2.
//   - Frame 2 has fft_inverse=0; frame_cnt=3; owner never skips a phase.
// - Stray pulses: fft_done and rx_done during TX, tx_busy glitch in RX -> no state change, outputs unchanged.
// - Timeout: TIMEOUT_CYCLES=64, no fft_done.
//   - seq_err=1 exactly 64 cycles after CORE entry; err_phase=2, mem_owner=0.
//   - err_clr -> IDLE next cycle.
// - Tie: fft_done on watchdog-expiry cycle -> TX_START, no error.
//   - Separately, cfg_en=0 for 200 cycles in RX with TIMEOUT 64 -> no error.
// - Reset mid-TX: rst 1 cycle -> IDLE, all outputs 0, frame_cnt 0 next cycle; cfg_en=0 during drop -> frame finishes then IDLE.

Source files
------------

// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types for the FFT frame sequencer: FSM states, memory-owner
// encoding and the default watchdog limit.
package fft_ctrl_pckg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_RX,
    SEQ_CORE_START,
    SEQ_CORE,
    SEQ_TX_START,
    SEQ_TX_WAIT,
    SEQ_TX,
    SEQ_ERROR
  } seq_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_RX,
    OWN_CORE,
    OWN_TX
  } mem_owner_t;

  localparam int unsigned SEQ_TIMEOUT_DFLT = 2**20;

  // Memory owner implied by a state; used on the next state so the owner
  // register switches on the same edge as the state register.
  function automatic mem_owner_t owner_of(input seq_state_t s);
    mem_owner_t o;
    o = OWN_NONE;
    case (s)
      SEQ_RX:                              o = OWN_RX;
      SEQ_CORE_START, SEQ_CORE:            o = OWN_CORE;
      SEQ_TX_START, SEQ_TX_WAIT, SEQ_TX:   o = OWN_TX;
      default:                             o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// the last allowed cycle. TIMEOUT_CYCLES = 0 removes the counter entirely.
module fft_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired = enable && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame scheduler for the FFT accelerator: RX -> COMPUTE -> TX with
// exclusive memory ownership per phase, start pulses and a phase watchdog.
module fft_frame_sequencer
  import fft_ctrl_pckg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = SEQ_TIMEOUT_DFLT,
  parameter int unsigned FRAME_CNT_WDT  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_en,
  input  logic                     cfg_inverse,
  input  logic                     err_clr,
  output logic                     rx_ready,
  input  logic                     rx_done,
  output logic                     fft_start,
  output logic                     fft_inverse,
  input  logic                     fft_done,
  output logic                     tx_ready,
  input  logic                     tx_busy,
  output logic [1:0]               mem_owner,
  output logic                     seq_busy,
  output logic                     seq_err,
  output logic [1:0]               err_phase,
  output logic [FRAME_CNT_WDT-1:0] frame_cnt
);

  seq_state_t               state_q, state_d;
  mem_owner_t               mem_owner_q, mem_owner_d;
  mem_owner_t               err_phase_q, err_phase_d;
  logic                     fft_inverse_q, fft_inverse_d;
  logic [FRAME_CNT_WDT-1:0] frame_cnt_q, frame_cnt_d;
  logic                     wdt_clear, wdt_en, wdt_expired;

  // Waiting in RX with cfg_en low is idle input, not a stalled agent.
  assign wdt_en = ((state_q == SEQ_RX) && cfg_en) ||
                  (state_q == SEQ_CORE) ||
                  (state_q == SEQ_TX_WAIT) ||
                  (state_q == SEQ_TX);
  assign wdt_clear = (state_d != state_q);

  fft_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clear  (wdt_clear),
    .enable (wdt_en),
    .expired(wdt_expired)
  );

  always_comb begin
    state_d       = state_q;
    fft_inverse_d = fft_inverse_q;
    frame_cnt_d   = frame_cnt_q;
    err_phase_d   = err_phase_q;
    // Completion is checked before expiry so a same-cycle done wins.
    case (state_q)
      SEQ_IDLE: begin
        if (cfg_en) begin
          state_d       = SEQ_RX;
          fft_inverse_d = cfg_inverse;
        end
      end
      SEQ_RX: begin
        if (rx_done)          state_d = SEQ_CORE_START;
        else if (wdt_expired) state_d = SEQ_ERROR;
      end
      SEQ_CORE_START: state_d = SEQ_CORE;
      SEQ_CORE: begin
        if (fft_done)         state_d = SEQ_TX_START;
        else if (wdt_expired) state_d = SEQ_ERROR;
      end
      SEQ_TX_START: state_d = SEQ_TX_WAIT;
      SEQ_TX_WAIT: begin
        if (tx_busy)          state_d = SEQ_TX;
        else if (wdt_expired) state_d = SEQ_ERROR;
      end
      SEQ_TX: begin
        if (!tx_busy) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (cfg_en) begin
            state_d       = SEQ_RX;
            fft_inverse_d = cfg_inverse;
          end else begin
            state_d = SEQ_IDLE;
          end
        end else if (wdt_expired) begin
          state_d = SEQ_ERROR;
        end
      end
      SEQ_ERROR: begin
        if (err_clr) begin
          state_d     = SEQ_IDLE;
          err_phase_d = OWN_NONE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    if ((state_d == SEQ_ERROR) && (state_q != SEQ_ERROR)) begin
      err_phase_d = mem_owner_q;
    end
    mem_owner_d = owner_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEQ_IDLE;
      mem_owner_q   <= OWN_NONE;
      err_phase_q   <= OWN_NONE;
      fft_inverse_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_owner_q   <= mem_owner_d;
      err_phase_q   <= err_phase_d;
      fft_inverse_q <= fft_inverse_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign rx_ready    = (state_q == SEQ_RX);
  assign fft_start   = (state_q == SEQ_CORE_START);
  assign tx_ready    = (state_q == SEQ_TX_START);
  assign seq_busy    = (state_q != SEQ_IDLE);
  assign seq_err     = (state_q == SEQ_ERROR);
  assign mem_owner   = mem_owner_q;
  assign err_phase   = err_phase_q;
  assign fft_inverse = fft_inverse_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: nominal and back-to-back frames,
// stray pulses, watchdog expiry/tie/exemption, reset mid-frame, count wrap.
module tb_fft_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_en = 1'b0, cfg_inverse = 1'b0, err_clr = 1'b0;
  logic       rx_done = 1'b0, fft_done = 1'b0, tx_busy = 1'b0;
  logic       rx_ready, fft_start, fft_inverse, tx_ready, seq_busy, seq_err;
  logic [1:0] mem_owner, err_phase;
  logic [3:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fft_frame_sequencer #(
    .TIMEOUT_CYCLES(64),
    .FRAME_CNT_WDT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_en     (cfg_en),
    .cfg_inverse(cfg_inverse),
    .err_clr    (err_clr),
    .rx_ready   (rx_ready),
    .rx_done    (rx_done),
    .fft_start  (fft_start),
    .fft_inverse(fft_inverse),
    .fft_done   (fft_done),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .mem_owner  (mem_owner),
    .seq_busy   (seq_busy),
    .seq_err    (seq_err),
    .err_phase  (err_phase),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rx_ready"},  rx_ready,    0);
    check_eq({tag, "_fft_start"}, fft_start,   0);
    check_eq({tag, "_fft_inv"},   fft_inverse, 0);
    check_eq({tag, "_tx_ready"},  tx_ready,    0);
    check_eq({tag, "_owner"},     mem_owner,   0);
    check_eq({tag, "_busy"},      seq_busy,    0);
    check_eq({tag, "_err"},       seq_err,     0);
    check_eq({tag, "_err_phase"}, err_phase,   0);
    check_eq({tag, "_frame_cnt"}, frame_cnt,   0);
  endtask

  // Entered with the DUT in RX; returns one tick after tx_busy falls.
  task automatic run_frame(input logic exp_inv, input int rx_wait, input int core_wait,
                           input int tx_len, input logic [3:0] exp_cnt);
    check_eq("frm_rx_ready", rx_ready, 1);
    check_eq("frm_owner_rx", mem_owner, 1);
    check_eq("frm_inverse", fft_inverse, exp_inv);
    ticks(rx_wait);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    check_eq("frm_fft_start", fft_start, 1);
    check_eq("frm_owner_core", mem_owner, 2);
    check_eq("frm_rx_ready_off", rx_ready, 0);
    tick();
    check_eq("frm_fft_start_1cyc", fft_start, 0);
    ticks(core_wait);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    check_eq("frm_tx_ready", tx_ready, 1);
    check_eq("frm_owner_tx", mem_owner, 3);
    tick();
    check_eq("frm_tx_ready_1cyc", tx_ready, 0);
    check_eq("frm_owner_txwait", mem_owner, 3);
    tx_busy = 1'b1; tick();
    ticks(tx_len - 1);
    tx_busy = 1'b0; tick();
    check_eq("frm_frame_cnt", frame_cnt, exp_cnt);
  endtask

  // Non-zero owners must advance RX -> CORE -> TX -> RX with no skipped phase.
  logic [1:0] prev_owner = 2'd0;
  always @(negedge clk) begin
    if ((mem_owner != prev_owner) && (prev_owner != 2'd0) && (mem_owner != 2'd0))
      check_eq("owner_order", mem_owner, (prev_owner == 2'd3) ? 32'd1 : 32'(prev_owner) + 32'd1);
    prev_owner = mem_owner;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state and idle with cfg_en low.
    do_reset();
    check_all_zero("reset");
    ticks(3);
    check_eq("idle_hold_busy", seq_busy, 0);

    // Nominal frame with IFFT selected.
    cfg_inverse = 1'b1; cfg_en = 1'b1; tick();
    check_eq("nom_busy", seq_busy, 1);
    run_frame(1'b1, 8, 18, 29, 4'd1);
    check_eq("nom_next_rx", rx_ready, 1);
    check_eq("nom_next_owner", mem_owner, 1);
    check_eq("nom_next_inv", fft_inverse, 1);

    // Back-to-back: inverse re-latched at frame 2; cfg_en dropped before frame 3.
    do_reset();
    cfg_en = 1'b1; cfg_inverse = 1'b1; tick();
    cfg_inverse = 1'b0;
    run_frame(1'b1, 2, 5, 4, 4'd1);
    run_frame(1'b0, 3, 4, 6, 4'd2);
    cfg_en = 1'b0;
    run_frame(1'b0, 1, 2, 3, 4'd3);
    check_eq("b2b_end_busy", seq_busy, 0);
    check_eq("b2b_end_owner", mem_owner, 0);
    check_eq("b2b_end_rx_ready", rx_ready, 0);

    // Stray pulses.
    do_reset();
    cfg_en = 1'b1; tick();
    tx_busy = 1'b1; tick(); tx_busy = 1'b0;
    check_eq("stray_txbusy_rx", rx_ready, 1);
    check_eq("stray_txbusy_owner", mem_owner, 1);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    check_eq("stray_fftdone_rx", rx_ready, 1);
    check_eq("stray_fftdone_txr", tx_ready, 0);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    tick();
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    check_eq("stray_rxdone_core", mem_owner, 2);
    check_eq("stray_rxdone_start", fft_start, 0);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    tick();
    tx_busy = 1'b1; tick();
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    check_eq("stray_tx_owner", mem_owner, 3);
    check_eq("stray_tx_start", fft_start, 0);
    check_eq("stray_tx_txready", tx_ready, 0);
    check_eq("stray_tx_rxready", rx_ready, 0);
    tx_busy = 1'b0; tick();
    check_eq("stray_frame_cnt", frame_cnt, 1);

    // CORE timeout: error exactly 64 cycles after CORE entry.
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    tick();
    ticks(63);
    check_eq("to_core_pre_err", seq_err, 0);
    check_eq("to_core_pre_owner", mem_owner, 2);
    tick();
    check_eq("to_core_err", seq_err, 1);
    check_eq("to_core_phase", err_phase, 2);
    check_eq("to_core_owner", mem_owner, 0);
    check_eq("to_core_busy", seq_busy, 1);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    check_eq("to_err_stray", seq_err, 1);
    cfg_en = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check_eq("errclr_err", seq_err, 0);
    check_eq("errclr_busy", seq_busy, 0);
    check_eq("errclr_phase", err_phase, 0);
    check_eq("errclr_cnt_kept", frame_cnt, 1);

    // Tie: fft_done on the expiry cycle wins.
    cfg_en = 1'b1; tick();
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    tick();
    ticks(63);
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    check_eq("tie_err", seq_err, 0);
    check_eq("tie_tx_ready", tx_ready, 1);
    tick();
    tx_busy = 1'b1; tick();
    tx_busy = 1'b0; tick();
    check_eq("tie_frame_cnt", frame_cnt, 2);

    // RX timeout with cfg_en high.
    ticks(63);
    check_eq("to_rx_pre_err", seq_err, 0);
    tick();
    check_eq("to_rx_err", seq_err, 1);
    check_eq("to_rx_phase", err_phase, 1);
    cfg_en = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // RX exempt while cfg_en is low.
    cfg_en = 1'b1; tick(); cfg_en = 1'b0;
    ticks(200);
    check_eq("rx_exempt_err", seq_err, 0);
    check_eq("rx_exempt_rx_ready", rx_ready, 1);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    tick();
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    tick();
    tx_busy = 1'b1; tick();
    tx_busy = 1'b0; tick();
    check_eq("rx_exempt_cnt", frame_cnt, 3);
    check_eq("rx_exempt_idle", seq_busy, 0);

    // Reset in the middle of TX.
    cfg_inverse = 1'b1; cfg_en = 1'b1; tick();
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    tick();
    fft_done = 1'b1; tick(); fft_done = 1'b0;
    tick();
    tx_busy = 1'b1; tick();
    check_eq("rstmid_owner_pre", mem_owner, 3);
    check_eq("rstmid_inv_pre", fft_inverse, 1);
    cfg_en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    tx_busy = 1'b0;
    check_all_zero("rstmid");
    tick();
    check_eq("rstmid_stay_idle", seq_busy, 0);

    // Frame counter wraps 15 -> 0.
    cfg_en = 1'b1; tick();
    for (int i = 1; i <= 15; i++) run_frame(1'b1, 1, 1, 1, 4'(i));
    cfg_en = 1'b0;
    run_frame(1'b1, 1, 1, 1, 4'd0);
    check_eq("wrap_idle", seq_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
